// File: rtl/mem_ctrl_hs.sv
// ---------------------------------------------------------------------------
// mem_ctrl_hs -- handshaked CPU memory-control stage.
//
// Accepts one decoded instruction per op_valid/op_ready transfer. ADR and
// ALU/PC ops complete in one cycle and write back through reg_data/reg_we.
// LDR/STR run a req/ack transaction on the unified memory port with wait
// states. A transaction that waits too long is aborted with a one-cycle
// err pulse. The program counter lives here.
//
// Ports:
//   Clk, Reset       rising-edge clock, synchronous active-low reset
//   op_valid/ready   instruction handshake (ready only in IDLE)
//   op_code          1100 ADR, 1101 LDR, 1110 STR, anything else ALU/PC op
//   SR1, SR2         source operands (ADR data / address, store data)
//   alu_result       ALU result for write-back
//   mem_req/rw/addr/wdata   memory request side (rw: 1=read, 0=write)
//   mem_rdata/ack    memory response side (ack is a one-cycle strobe)
//   reg_data/reg_we  register write-back, reg_we is a one-cycle pulse
//   pc               program counter
//   err              one-cycle timeout pulse
// ---------------------------------------------------------------------------

// Protocol invariants of the controller outputs, kept apart from the datapath.
module mem_ctrl_hs_chk #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input logic              Clk,
    input logic              Reset,
    input logic              op_ready,
    input logic              mem_req,
    input logic              mem_rw,
    input logic [ADDR_W-1:0] mem_addr,
    input logic [DATA_W-1:0] mem_wdata,
    input logic              reg_we,
    input logic              err
);

    // A timeout never produces a write-back in the same cycle.
    a_no_we_with_err: assert property (@(posedge Clk) disable iff (!Reset)
        !(reg_we && err));

    // The controller is ready exactly when no request is outstanding.
    a_ready_vs_req: assert property (@(posedge Clk) disable iff (!Reset)
        op_ready == !mem_req);

    // While a request stays up, its command fields do not move.
    a_req_stable: assert property (@(posedge Clk) disable iff (!Reset)
        (mem_req && $past(mem_req)) |->
            ($stable(mem_addr) && $stable(mem_rw) && $stable(mem_wdata)));

    // err is a single-cycle pulse.
    a_err_pulse: assert property (@(posedge Clk) disable iff (!Reset)
        err |=> !err);

endmodule

module mem_ctrl_hs #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                WAIT_MAX = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] SR1,
    input  logic [DATA_W-1:0] SR2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_we,
    output logic [ADDR_W-1:0] pc,
    output logic              err
);

    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    // Counter only has to reach WAIT_MAX; the transaction ends on that cycle.
    localparam int               CNT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              accept_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              unused_sr1_hi_s;

    // Only the low ADDR_W bits of SR1 form a memory address.
    assign unused_sr1_hi_s = ^SR1[DATA_W-1:ADDR_W];

    // Ready is decoded straight from the state register (no extra cycle).
    assign op_ready = (state_r == ST_IDLE);
    assign accept_s = op_valid & op_ready;
    // Natural ADDR_W-bit wrap from all-ones to zero.
    assign pc_inc_s = pc + ADDR_W'(1);

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            pc         <= PC_RESET;
            mem_req    <= 1'b0;
            mem_rw     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            reg_data   <= '0;
            reg_we     <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Strobes default low; only a completing op raises them.
            reg_we <= 1'b0;
            err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (op_code)
                            OP_ADR: begin
                                reg_data <= SR1;
                                reg_we   <= 1'b1;
                            end
                            OP_LDR: begin
                                mem_req    <= 1'b1;
                                mem_rw     <= 1'b1;
                                mem_addr   <= SR1[ADDR_W-1:0];
                                wait_cnt_r <= '0;
                                state_r    <= ST_MEM;
                            end
                            OP_STR: begin
                                mem_req    <= 1'b1;
                                mem_rw     <= 1'b0;
                                mem_addr   <= SR1[ADDR_W-1:0];
                                mem_wdata  <= SR2;
                                wait_cnt_r <= '0;
                                state_r    <= ST_MEM;
                            end
                            default: begin
                                // ALU/PC op: write back and step the PC; the
                                // memory address follows the PC for fetch.
                                reg_data <= alu_result;
                                reg_we   <= 1'b1;
                                pc       <= pc_inc_s;
                                mem_addr <= pc_inc_s;
                                mem_rw   <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEM: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    // mem_rw still identifies the op: read means LDR.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= ST_IDLE;
                        if (mem_rw) begin
                            reg_data <= mem_rdata;
                            reg_we   <= 1'b1;
                        end else begin
                            reg_we <= 1'b0;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: drop any request and recover.
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    mem_ctrl_hs_chk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_chk (
        .Clk       (Clk),
        .Reset     (Reset),
        .op_ready  (op_ready),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .reg_we    (reg_we),
        .err       (err)
    );

endmodule

// File: tb/tb_mem_ctrl_hs.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for mem_ctrl_hs (default parameters:
// DATA_W=32, ADDR_W=8, PC_RESET=0, WAIT_MAX=15). Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_mem_ctrl_hs;

    logic        Clk;
    logic        Reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] SR1;
    logic [31:0] SR2;
    logic [31:0] alu_result;
    logic        mem_req;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] reg_data;
    logic        reg_we;
    logic [7:0]  pc;
    logic        err;

    int vectors;
    int miscompares;

    localparam logic [3:0] OP_ALU = 4'b0000;
    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    mem_ctrl_hs dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .SR1        (SR1),
        .SR2        (SR2),
        .alu_result (alu_result),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .reg_data   (reg_data),
        .reg_we     (reg_we),
        .pc         (pc),
        .err        (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b0;
        op_valid    = 1'b0;
        op_code     = OP_ALU;
        SR1         = 32'h0;
        SR2         = 32'h0;
        alu_result  = 32'h0;
        mem_rdata   = 32'h0;
        mem_ack     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pc",       {24'h0, pc},        32'h0);
        check("rst_req",      {31'h0, mem_req},   32'h0);
        check("rst_rw",       {31'h0, mem_rw},    32'h1);
        check("rst_addr",     {24'h0, mem_addr},  32'h0);
        check("rst_wdata",    mem_wdata,          32'h0);
        check("rst_rdata",    reg_data,           32'h0);
        check("rst_we",       {31'h0, reg_we},    32'h0);
        check("rst_err",      {31'h0, err},       32'h0);
        check("rst_ready",    {31'h0, op_ready},  32'h1);

        // First ALU op
        Reset      = 1'b1;
        op_valid   = 1'b1;
        op_code    = OP_ALU;
        alu_result = 32'hDEADBEEF;
        tick();
        op_valid = 1'b0;
        check("alu1_we",      {31'h0, reg_we},    32'h1);
        check("alu1_data",    reg_data,           32'hDEADBEEF);
        check("alu1_pc",      {24'h0, pc},        32'h1);
        check("alu1_addr",    {24'h0, mem_addr},  32'h1);
        check("alu1_rw",      {31'h0, mem_rw},    32'h1);
        tick();
        check("alu1_we_off",  {31'h0, reg_we},    32'h0);

        // Reset held low clears everything again
        Reset = 1'b0;
        tick();
        check("rst2_pc",      {24'h0, pc},        32'h0);
        check("rst2_addr",    {24'h0, mem_addr},  32'h0);
        check("rst2_data",    reg_data,           32'h0);
        Reset = 1'b1;

        // ADR writes SR1 and leaves pc alone
        op_valid = 1'b1;
        op_code  = OP_ADR;
        SR1      = 32'h11223344;
        tick();
        op_valid = 1'b0;
        check("adr_we",       {31'h0, reg_we},    32'h1);
        check("adr_data",     reg_data,           32'h11223344);
        check("adr_pc",       {24'h0, pc},        32'h0);

        // 255 back-to-back ALU ops bring pc to 0xFF, the next wraps to 0
        op_valid = 1'b1;
        op_code  = OP_ALU;
        for (int i = 0; i < 255; i++) begin
            alu_result = i;
            tick();
        end
        check("pc_ff",        {24'h0, pc},        32'hFF);
        check("pc_ff_ready",  {31'h0, op_ready},  32'h1);
        alu_result = 32'h0BADF00D;
        tick();
        check("pc_wrap",      {24'h0, pc},        32'h0);
        check("pc_wrap_addr", {24'h0, mem_addr},  32'h0);
        check("pc_wrap_data", reg_data,           32'h0BADF00D);

        // Three back-to-back ALU ops
        alu_result = 32'h00000001;
        tick();
        check("b2b1_we",      {31'h0, reg_we},    32'h1);
        check("b2b1_pc",      {24'h0, pc},        32'h1);
        check("b2b1_ready",   {31'h0, op_ready},  32'h1);
        alu_result = 32'h00000002;
        tick();
        check("b2b2_we",      {31'h0, reg_we},    32'h1);
        check("b2b2_data",    reg_data,           32'h00000001 + 32'h1);
        check("b2b2_ready",   {31'h0, op_ready},  32'h1);
        alu_result = 32'h00000003;
        tick();
        op_valid = 1'b0;
        check("b2b3_we",      {31'h0, reg_we},    32'h1);
        check("b2b3_pc",      {24'h0, pc},        32'h3);
        tick();
        check("b2b_idle_we",  {31'h0, reg_we},    32'h0);

        // LDR at 0x40 (upper SR1 bits ignored), ack after three wait cycles
        op_valid = 1'b1;
        op_code  = OP_LDR;
        SR1      = 32'hABCDEF40;
        tick();
        op_valid = 1'b0;
        check("ldr_req0",     {31'h0, mem_req},   32'h1);
        check("ldr_rw",       {31'h0, mem_rw},    32'h1);
        check("ldr_addr",     {24'h0, mem_addr},  32'h40);
        check("ldr_ready0",   {31'h0, op_ready},  32'h0);
        // An op offered during MEM is ignored
        op_valid   = 1'b1;
        op_code    = OP_ALU;
        alu_result = 32'h77777777;
        tick();
        op_valid = 1'b0;
        check("ldr_req1",     {31'h0, mem_req},   32'h1);
        check("ldr_ign_we",   {31'h0, reg_we},    32'h0);
        check("ldr_ign_pc",   {24'h0, pc},        32'h3);
        tick();
        check("ldr_req2",     {31'h0, mem_req},   32'h1);
        check("ldr_ready2",   {31'h0, op_ready},  32'h0);
        tick();
        check("ldr_req3",     {31'h0, mem_req},   32'h1);
        check("ldr_addr3",    {24'h0, mem_addr},  32'h40);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack   = 1'b0;
        check("ldr_req_done", {31'h0, mem_req},   32'h0);
        check("ldr_we",       {31'h0, reg_we},    32'h1);
        check("ldr_data",     reg_data,           32'h12345678);
        check("ldr_ready",    {31'h0, op_ready},  32'h1);
        tick();
        check("ldr_we_off",   {31'h0, reg_we},    32'h0);

        // STR with immediate ack
        op_valid = 1'b1;
        op_code  = OP_STR;
        SR1      = 32'h00000010;
        SR2      = 32'hA5A5A5A5;
        tick();
        op_valid = 1'b0;
        check("str_req",      {31'h0, mem_req},   32'h1);
        check("str_rw",       {31'h0, mem_rw},    32'h0);
        check("str_addr",     {24'h0, mem_addr},  32'h10);
        check("str_wdata",    mem_wdata,          32'hA5A5A5A5);
        mem_ack = 1'b1;
        tick();
        check("str_req_done", {31'h0, mem_req},   32'h0);
        check("str_we",       {31'h0, reg_we},    32'h0);
        check("str_data_keep",reg_data,           32'h12345678);
        check("str_pc",       {24'h0, pc},        32'h3);
        // Ack while IDLE is ignored
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req", {31'h0, mem_req},   32'h0);
        check("idle_ack_we",  {31'h0, reg_we},    32'h0);

        // LDR with no ack: 16 request cycles, then abort with err
        op_valid = 1'b1;
        op_code  = OP_LDR;
        SR1      = 32'h00000020;
        tick();
        op_valid = 1'b0;
        check("to_req0",      {31'h0, mem_req},   32'h1);
        for (int k = 1; k <= 15; k++) begin
            tick();
        end
        check("to_req15",     {31'h0, mem_req},   32'h1);
        check("to_err15",     {31'h0, err},       32'h0);
        tick();
        check("to_req_drop",  {31'h0, mem_req},   32'h0);
        check("to_err",       {31'h0, err},       32'h1);
        check("to_we",        {31'h0, reg_we},    32'h0);
        check("to_pc",        {24'h0, pc},        32'h3);
        check("to_ready",     {31'h0, op_ready},  32'h1);
        tick();
        check("to_err_off",   {31'h0, err},       32'h0);

        // Ack on the timeout cycle wins
        op_valid = 1'b1;
        op_code  = OP_LDR;
        SR1      = 32'h00000030;
        tick();
        op_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
        end
        check("ackto_req15",  {31'h0, mem_req},   32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        check("ackto_err",    {31'h0, err},       32'h0);
        check("ackto_we",     {31'h0, reg_we},    32'h1);
        check("ackto_data",   reg_data,           32'hCAFEF00D);
        check("ackto_req",    {31'h0, mem_req},   32'h0);

        // Reset during a waiting LDR, then a late ack
        op_valid = 1'b1;
        op_code  = OP_LDR;
        SR1      = 32'h00000050;
        tick();
        op_valid = 1'b0;
        tick();
        check("rmem_req",     {31'h0, mem_req},   32'h1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("rmem_req_off", {31'h0, mem_req},   32'h0);
        check("rmem_ready",   {31'h0, op_ready},  32'h1);
        check("rmem_we",      {31'h0, reg_we},    32'h0);
        check("rmem_pc",      {24'h0, pc},        32'h0);
        check("rmem_rw",      {31'h0, mem_rw},    32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h99999999;
        tick();
        mem_ack = 1'b0;
        check("late_ack_we",  {31'h0, reg_we},    32'h0);
        check("late_ack_data",reg_data,           32'h0);
        check("late_ack_req", {31'h0, mem_req},   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
